// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result/flag capture behind a two-entry FIFO.
// It derives the N/Z/C/V flags at push time and stores them with each result.
// It also keeps a sticky overflow bit for the current operation sequence.
module alu_result_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_op,
    input  logic [7:0] in_res,
    input  logic       in_cout,
    input  logic       in_a7,
    input  logic       in_b7,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_res,
    output logic [3:0] out_flags,
    output logic       sticky_v,
    input  logic       clr_sticky
);

    localparam int unsigned RES_W  = 8;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned PTR_W  = 1;
    localparam int unsigned CNT_W  = 2;

    logic [RES_W-1:0]  res_mem_q  [DEPTH];
    logic [RES_W-1:0]  res_mem_d  [DEPTH];
    logic [FLAG_W-1:0] flag_mem_q [DEPTH];
    logic [FLAG_W-1:0] flag_mem_d [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [RES_W-1:0]  out_res_q, out_res_d;
    logic [FLAG_W-1:0] out_flags_q, out_flags_d;
    logic              sticky_q, sticky_d;

    logic              push;
    logic              pop;
    logic              flag_v;
    logic [FLAG_W-1:0] flags_new;

    // Handshakes qualified by registered state only
    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Status flags of the incoming result; V depends on whether B was added or subtracted
    always_comb begin
        flag_v    = 1'b0;
        flags_new = '0;
        if (in_op) begin
            flag_v = (in_a7 != in_b7) && (in_res[7] != in_a7);
        end else begin
            flag_v = (in_a7 == in_b7) && (in_res[7] != in_a7);
        end
        flags_new = {in_res[7], (in_res == RES_W'(0)), in_cout, flag_v};
    end

    // Next-state for storage, pointers, count, and the registered head/handshake outputs
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            res_mem_d[i]  = res_mem_q[i];
            flag_mem_d[i] = flag_mem_q[i];
        end
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_flags_d = out_flags_q;
        sticky_d    = sticky_q;

        if (push) begin
            res_mem_d[wr_ptr_q]  = in_res;
            flag_mem_d[wr_ptr_q] = flags_new;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        in_ready_d  = (count_d < CNT_W'(DEPTH));
        out_valid_d = (count_d != CNT_W'(0));

        // Head is pre-selected from next-state so out_* are true registers; zero while empty
        if (out_valid_d) begin
            out_res_d   = res_mem_d[rd_ptr_d];
            out_flags_d = flag_mem_d[rd_ptr_d];
        end else begin
            out_res_d   = '0;
            out_flags_d = '0;
        end

        // An overflowing push takes priority over a same-cycle clear
        if (push && flag_v) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            res_mem_q[i]  <= res_mem_d[i];
            flag_mem_q[i] <= flag_mem_d[i];
        end
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_flags_q <= out_flags_d;
            sticky_q    <= sticky_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_flags = out_flags_q;
    assign sticky_v  = sticky_q;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage that sits directly downstream of the combinational 8-bit adder/subtractor. It captures each result (`Diff`/`Sum` plus `Cout`), derives the N/Z/C/V status flags, and buffers up to two results in a small FIFO behind a valid/ready handshake. It decouples the combinational datapath from the consumer (register file / display logic) and keeps a sticky overflow indicator for the current operation sequence.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; fixed at 2 in this revision, so count fits in 2 bits.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  upstream result valid
- `in_ready`  output  1  stage can accept (FIFO not full)
- `in_op`  input  1  0 = add, 1 = subtract
- `in_res`  input  8  `Sum`/`Diff` from the arithmetic unit
- `in_cout`  input  1  `Cout` from the arithmetic unit
- `in_a7`  input  1  MSB of operand A
- `in_b7`  input  1  MSB of operand B, as applied to the operation, not inverted
- `out_valid`  output  1  head entry valid
- `out_ready`  input  1  consumer accepts head entry
- `out_res`  output  8  head result
- `out_flags`  output  4  head flags {N, Z, C, V}
- `sticky_v`  output  1  OR of V over all accepted entries since reset/clear
- `clr_sticky`  input  1  synchronous clear of `sticky_v`

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- Flags are computed at push time and stored with the entry:
  - N = `in_res[7]`
  - Z = (`in_res` == 0)
  - C = `in_cout` for both ops. For subtract, `Cout`=1 means no borrow (A ≥ B unsigned).
  - V, add: `in_a7 == in_b7 && in_res[7] != in_a7`
  - V, subtract: `in_a7 != in_b7 && in_res[7] != in_a7`
- FIFO: 2 entries, read pointer, write pointer and 2-bit count (0..2). Pointers wrap modulo 2.
- `in_ready` = (count < 2), driven from registered count only. There is no combinational path from `out_ready` to `in_ready`, so a push is refused when full even if a pop occurs in the same cycle.
- Simultaneous push and pop with count = 1: count stays 1, head advances, new entry written.
- Simultaneous push and pop with count = 0: impossible, because `out_valid` = 0.
- `out_valid` = (count != 0). `out_res`/`out_flags` show the entry at the read pointer. They hold stable while `out_valid && !out_ready`.
- `sticky_v`:
  - Set on any push whose V = 1.
  - `clr_sticky` clears it.
  - `clr_sticky` together with a V=1 push in the same cycle: set wins, `sticky_v` = 1.
- Pop with `out_valid` = 0 is ignored.
- Push with `in_ready` = 0 is ignored; data is dropped and upstream must hold.

## Timing
- Reset values, asynchronous on `rst` high:
  - count = 0, pointers = 0
  - `out_valid` = 0, `in_ready` = 1
  - `out_res` = 8'h00, `out_flags` = 4'b0000, `sticky_v` = 0
- Storage contents are don't-care after reset, but outputs read as zero while empty.
- Latency: data pushed at edge k is visible on `out_*` with `out_valid` = 1 after edge k (one cycle). There is no same-cycle bypass.
- Throughput: one result per cycle sustained when the consumer holds `out_ready` = 1.
- `sticky_v` updates on the same edge as the push.
- Reset mid-operation: all queued entries are discarded immediately; `in_ready` returns to 1 asynchronously.
- Upstream rule: `in_*` must hold stable while `in_valid && !in_ready`.

## Test plan
- Reset, then subtract 8'd1 − 8'd1 (`in_res`=0, `in_cout`=1, a7=b7=0) with `out_ready`=1 -> next cycle `out_res`=0, flags {N,Z,C,V}=4'b0110, `sticky_v`=0.
- Subtract 8'd240 − 8'd15 (`in_res`=8'd225, `in_cout`=1, a7=1, b7=0) -> flags 4'b1010.
- Subtract 8'd0 − 8'd1 (`in_res`=8'hFF, `in_cout`=0, a7=b7=0) -> flags 4'b1000, V=0.
- Add 8'h7F + 8'h01 (`in_res`=8'h80, `in_cout`=0) -> flags 4'b1001 and `sticky_v`=1. Then `clr_sticky` pulse -> `sticky_v`=0 next cycle.
- Backpressure: `out_ready`=0, push 8'h11 then 8'h22 -> `in_ready`=0 after the second push, and a third push of 8'h33 is ignored. Raise `out_ready` -> outputs 8'h11 then 8'h22 in order; `in_ready` returns to 1 one cycle after the first pop.
- Assert `rst` while 2 entries are queued -> `out_valid`=0, `in_ready`=1, `out_res`=0, `sticky_v`=0 immediately. The next push of 8'h05 emerges as the first output.
